multicycle_controller: RTL

Multicycle sequencing controller for the team's MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. Per state, it drives the datapath's select and enable signals: register-file write, ALU operand and operation selects, PC update, instruction-register load and unified-memory request. It sits beside the datapath, consuming `op`, `funct` and the ALU `zero` flag, and it handshakes with a shared instruction/data memory that may insert wait states.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller.
// MULTICYCLE_ILLEGAL_TRAP_EN adds the ERROR state.
package mips_ctrl_pkg;

  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ERROR    = 4'd13;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the state-supplied ALU class and funct
// field onto the datapath ALU operation code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [3:0]  funct,
  output logic [2:0]  alucontrol
);

  // Class select, with R-type funct lookup
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          4'b0000: alucontrol = ALU_ADD;
          4'b0010: alucontrol = ALU_SUB;
          4'b0100: alucontrol = ALU_AND;
          4'b0101: alucontrol = ALU_OR;
          4'b1010: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM with memory wait states.
// MULTICYCLE_ILLEGAL_TRAP_EN traps unknown opcodes.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  aluop_e     aluop;
  logic       op_mem;
  logic       op_known;
  logic [3:0] bad_next;

  assign op_mem   = (op == OP_LW) || (op == OP_SW);
  assign op_known = op_mem || (op == OP_R) ||
                    (op == OP_BEQ) || (op == OP_ADDI) ||
                    (op == OP_J);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign bad_next = S_ERROR;
`else
  assign bad_next = S_FETCH;
`endif

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_mem:          state_d = S_MEMADR;
          (op == OP_R):    state_d = S_EXECUTE;
          (op == OP_BEQ):  state_d = S_BEQ;
          (op == OP_ADDI): state_d = S_ADDIEX;
          (op == OP_J):    state_d = S_JUMP;
          default:         state_d = bad_next;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_LW) ? S_MEMREAD
                                : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_ERROR:    state_d = S_ERROR;
`endif
      default:    state_d = S_START;
    endcase
  end

  // State register; reset forces START asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_START;
    else        state_q <= state_d;
  end

  // Per-state datapath controls
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RD2;
    aluop      = ALUOP_ADD;
    pcsrc      = PCSRC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        instr_done = !op_known;
`endif
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_ERROR: illegal_op = 1'b1;
`endif
      default: ;
    endcase
    if (state_q == S_START) aluop = ALUOP_ADD;
  end

  // ALU op is zero in states that leave the ALU idle
  logic [2:0] alu_raw;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_raw)
  );

  // Only states that actually use the ALU present an opcode
  always_comb begin
    alucontrol = 3'b000;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR,
      S_EXECUTE, S_BEQ, S_ADDIEX:
        alucontrol = alu_raw;
      default: alucontrol = 3'b000;
    endcase
  end

endmodule
